// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes it into
// instruction memory and releases the core once the XOR checksum verifies.
// Optional inter-byte timeout enabled by defining BOOT_TIMEOUT_EN.
`timescale 1ns/1ps

module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 256
`ifdef BOOT_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 50000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_run,
    output logic        done,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;
    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERROR} state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       wbuf_q;
    logic [7:0]        csum_q;

    logic              acc;
    logic              in_frame;
    logic              abort;
    logic              word_done;
    logic [15:0]       len_full;
    logic [IDX_W-1:0]  idx_inc;

    assign acc       = rx_valid & rx_ready;
    assign in_frame  = state_q inside {LEN0, LEN1, DATA, CSUM};
    assign len_full  = {rx_data, len_q[7:0]};
    assign idx_inc   = idx_q + IDX_W'(1);
    assign word_done = acc && (state_q == DATA) && (byte_cnt_q == 2'd3);

`ifdef BOOT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Cycles since the last accepted byte while a frame is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 tmo_cnt_q <= '0;
        else if (!in_frame || acc) tmo_cnt_q <= '0;
        else                      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end

    assign abort = in_frame && !acc && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else if (acc) begin
            case (state_q)
                IDLE: if (rx_data == SYNC) state_d = LEN0;
                LEN0: state_d = LEN1;
                LEN1: begin
                    if (len_full > MAX_N)       state_d = ERROR;
                    else if (len_full == 16'd0) state_d = CSUM;
                    else                        state_d = DATA;
                end
                DATA: if (word_done && (16'(idx_inc) == len_q)) state_d = CSUM;
                CSUM: state_d = (rx_data == csum_q) ? RUN : ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    // Frame datapath: length, word buffer, word index and running checksum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            wbuf_q     <= '0;
            csum_q     <= '0;
        end else if (abort) begin
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
        end else if (acc) begin
            case (state_q)
                LEN0: len_q[7:0]  <= rx_data;
                LEN1: len_q[15:8] <= rx_data;
                DATA: begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    csum_q     <= csum_q ^ rx_data;
                    case (byte_cnt_q)
                        2'd0:    wbuf_q[7:0]   <= rx_data;
                        2'd1:    wbuf_q[15:8]  <= rx_data;
                        2'd2:    wbuf_q[23:16] <= rx_data;
                        default: idx_q         <= idx_inc;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Registered outputs derived from the next state and the completed word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= '0;
            core_run  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rx_ready <= state_d inside {IDLE, LEN0, LEN1, DATA, CSUM};
            imem_we  <= word_done;
            core_run <= (state_d == RUN);
            done     <= (state_d == RUN);
            err      <= (state_d == ERROR);
            if (word_done) begin
                imem_addr <= 32'({idx_q, 2'b00});
                imem_wd   <= {rx_data, wbuf_q};
            end
        end
    end

endmodule
